// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, address type, reset PC default,
// fetch-side FSM state encoding and return-prediction FIFO depth.
package y86_pkg;

    typedef logic [63:0] addr_t;
    typedef logic [3:0]  icode_t;

    localparam icode_t IHALT   = 4'h0;
    localparam icode_t INOP    = 4'h1;
    localparam icode_t IRRMOVQ = 4'h2;
    localparam icode_t IIRMOVQ = 4'h3;
    localparam icode_t IRMMOVQ = 4'h4;
    localparam icode_t IMRMOVQ = 4'h5;
    localparam icode_t IOPQ    = 4'h6;
    localparam icode_t IJXX    = 4'h7;
    localparam icode_t ICALL   = 4'h8;
    localparam icode_t IRET    = 4'h9;
    localparam icode_t IPUSHQ  = 4'hA;
    localparam icode_t IPOPQ   = 4'hB;

    localparam addr_t RESET_PC_DEFAULT = 64'h0;

    // Entries in the FIFO of outstanding RAS-predicted return targets
    localparam int unsigned PRED_DEPTH = 4;

    typedef enum logic {
        FS_IDLE,
        FS_RET_WAIT
    } fetch_state_t;

    // Jumps are predicted taken and calls always go to their target
    function automatic logic takes_valc(input icode_t ic);
        return (ic == IJXX) || (ic == ICALL);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack plus FIFO of predicted return targets awaiting
// resolution in write-back. Used only when PC_RAS_EN is defined.
// The stack is circular: pushing when full overwrites the oldest entry.
module pc_ras
    import y86_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  addr_t push_addr,
    input  logic  pop,
    input  logic  clear,
    output addr_t top,
    output logic  empty,
    input  logic  pred_push,
    input  addr_t pred_addr,
    input  logic  pred_pop,
    input  logic  pred_clear,
    output addr_t pred_head,
    output logic  pred_empty
);

    localparam int unsigned AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [AW:0] RAS_FULL = (AW+1)'(RAS_DEPTH);

    addr_t           stk [RAS_DEPTH];
    logic [AW-1:0]   sp_q;
    logic [AW:0]     cnt_q;

    addr_t           fifo [PRED_DEPTH];
    logic [1:0]      pw_q;
    logic [1:0]      pr_q;
    logic [2:0]      pn_q;
    logic            pop_eff;
    logic            ovf;

    assign top        = stk[sp_q - AW'(1)];
    assign empty      = (cnt_q == '0);
    assign pred_head  = fifo[pr_q];
    assign pred_empty = (pn_q == '0);

    assign pop_eff = pred_pop && (pn_q != '0);
    assign ovf     = pred_push && !pop_eff && (pn_q == 3'(PRED_DEPTH));

    // Stack pointer and occupancy; a clear in the same cycle as a push keeps the new entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            sp_q  <= push ? AW'(1) : '0;
            cnt_q <= push ? (AW+1)'(1) : '0;
        end else if (push) begin
            sp_q <= sp_q + AW'(1);
            if (cnt_q != RAS_FULL) cnt_q <= cnt_q + (AW+1)'(1);
        end else if (pop && !empty) begin
            sp_q  <= sp_q - AW'(1);
            cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

    // Stack storage
    always_ff @(posedge clk) begin
        if (push) stk[clear ? '0 : sp_q] <= push_addr;
    end

    // Prediction FIFO pointers; overflow drops the oldest prediction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pw_q <= '0;
            pr_q <= '0;
            pn_q <= '0;
        end else if (pred_clear) begin
            pr_q <= '0;
            pw_q <= pred_push ? 2'd1 : 2'd0;
            pn_q <= pred_push ? 3'd1 : 3'd0;
        end else begin
            if (pred_push)        pw_q <= pw_q + 2'd1;
            if (pop_eff || ovf)   pr_q <= pr_q + 2'd1;
            pn_q <= pn_q + {2'b00, pred_push} - {2'b00, pop_eff} - {2'b00, ovf};
        end
    end

    // Prediction FIFO storage
    always_ff @(posedge clk) begin
        if (pred_push) fifo[pred_clear ? 2'd0 : pw_q] <= pred_addr;
    end

endmodule

// File: rtl/pc_select_fetch.sv
// Fetch-side next-PC register and fetch PC selector for the pipelined Y86-64 core.
// Chooses between predicted PC, M-stage jxx fall-through and W-stage ret target,
// tracks outstanding rets, requests fetch bubbles and counts redirects.
// Optional feature macro: PC_RAS_EN (return-address-stack prediction of ret).
module pc_select_fetch
    import y86_pkg::*;
#(
    parameter addr_t       RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       f_icode,
    input  logic [63:0]      f_valC,
    input  logic [63:0]      f_valP,
    input  logic             f_stall,
    input  logic [3:0]       M_icode,
    input  logic             M_cnd,
    input  logic [63:0]      M_valA,
    input  logic [3:0]       W_icode,
    input  logic [63:0]      W_valM,
    output logic [63:0]      f_pc,
    output logic             f_bubble_req,
    output logic             flush_req,
    output logic [CNT_W-1:0] mispred_cnt
);

    addr_t            f_predpc_q;
    fetch_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;

    logic  jxx_mispred;
    logic  w_ret;
    logic  f_ret;
    logic  ras_hit;
    logic  ras_miss;
    logic  ret_redirect;
    logic  enter_wait;
    addr_t pred_pc;

    assign jxx_mispred = (M_icode == IJXX) && !M_cnd;
    assign w_ret       = (W_icode == IRET);
    assign f_ret       = (f_icode == IRET);

`ifdef PC_RAS_EN
    addr_t ras_top;
    logic  ras_empty;
    addr_t pred_head;
    logic  pred_empty;

    assign ras_hit      = f_ret && !ras_empty;
    // A W-stage ret with no queued prediction went down the RET_WAIT path
    assign ras_miss     = w_ret && !pred_empty && (pred_head != W_valM);
    assign ret_redirect = w_ret && (pred_empty || (pred_head != W_valM));

    pc_ras #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       ((f_icode == ICALL) && !f_stall),
        .push_addr  (f_valP),
        .pop        (ras_hit && !f_stall),
        .clear      (ras_miss),
        .top        (ras_top),
        .empty      (ras_empty),
        .pred_push  (ras_hit && !f_stall),
        .pred_addr  (ras_top),
        .pred_pop   (w_ret),
        .pred_clear (jxx_mispred),
        .pred_head  (pred_head),
        .pred_empty (pred_empty)
    );

    assign pred_pc = takes_valc(f_icode) ? f_valC :
                     ras_hit             ? ras_top : f_valP;
`else
    // RAS_DEPTH only sizes the stack in the RAS build
    if (RAS_DEPTH == 0) begin : g_no_ras_depth
    end

    assign ras_hit      = 1'b0;
    assign ras_miss     = 1'b0;
    assign ret_redirect = w_ret;
    assign pred_pc      = takes_valc(f_icode) ? f_valC : f_valP;
`endif

    assign enter_wait = f_ret && !f_stall && !ras_hit;

    assign f_pc         = jxx_mispred  ? M_valA :
                          ret_redirect ? W_valM : f_predpc_q;
    assign flush_req    = jxx_mispred || ras_miss;
    assign f_bubble_req = (state_q == FS_RET_WAIT);
    assign mispred_cnt  = cnt_q;

    // Predicted-PC register, held while fetch is stalled
    always_ff @(posedge clk) begin
        if (!rst_n)        f_predpc_q <= RESET_PC;
        else if (!f_stall) f_predpc_q <= pred_pc;
    end

    // Ret-wait FSM: a W ret that coincides with a newly fetched ret re-arms the wait
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
        end else begin
            unique case (state_q)
                FS_IDLE: begin
                    if (enter_wait) state_q <= FS_RET_WAIT;
                end
                FS_RET_WAIT: begin
                    if (jxx_mispred) state_q <= FS_IDLE;
                    else if (w_ret)  state_q <= enter_wait ? FS_RET_WAIT : FS_IDLE;
                end
                default: state_q <= FS_IDLE;
            endcase
        end
    end

    // Saturating redirect counter
    always_ff @(posedge clk) begin
        if (!rst_n)                      cnt_q <= '0;
        else if (flush_req && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_pc_select_fetch.sv
// Directed bench for pc_select_fetch: main instance (RESET_PC=0x100, 16-bit counter)
// and a second instance with a 2-bit counter for saturation. RAS scenario is
// compiled only when PC_RAS_EN is defined.
module tb_pc_select_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  f_icode;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic        f_stall;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;

    logic [63:0] f_pc;
    logic        f_bubble_req;
    logic        flush_req;
    logic [15:0] mispred_cnt;

    logic [63:0] f_pc2;
    logic        bub2;
    logic        flush2;
    logic [1:0]  cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_select_fetch #(
        .RESET_PC (64'h100),
        .CNT_W    (16),
        .RAS_DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
        .f_stall(f_stall), .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM), .f_pc(f_pc), .f_bubble_req(f_bubble_req),
        .flush_req(flush_req), .mispred_cnt(mispred_cnt)
    );

    pc_select_fetch #(
        .RESET_PC (64'h100),
        .CNT_W    (2),
        .RAS_DEPTH(8)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n), .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
        .f_stall(f_stall), .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
        .W_icode(W_icode), .W_valM(W_valM), .f_pc(f_pc2), .f_bubble_req(bub2),
        .flush_req(flush2), .mispred_cnt(cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        f_icode = 4'h1; f_valC = '0; f_valP = '0; f_stall = 1'b0;
        M_icode = 4'h1; M_cnd = 1'b1; M_valA = '0;
        W_icode = 4'h1; W_valM = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (f_pc !== 64'h100) begin n_bad++; $display("FAIL reset_pc got=%h exp=%h", f_pc, 64'h100); end
        n_cmp++; if (mispred_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d exp=0", mispred_cnt); end
        n_cmp++; if (f_bubble_req !== 1'b0) begin n_bad++; $display("FAIL reset_bubble got=%b exp=0", f_bubble_req); end
        n_cmp++; if (flush_req !== 1'b0) begin n_bad++; $display("FAIL reset_flush got=%b exp=0", flush_req); end
    endtask

    task automatic test_jxx();
        f_icode = 4'h7; f_valC = 64'h40; f_valP = 64'h49;
        step();
        n_cmp++; if (f_pc !== 64'h40) begin n_bad++; $display("FAIL jxx_pred got=%h exp=%h", f_pc, 64'h40); end
        f_icode = 4'h1; f_valP = 64'h41;
        step();
        f_valP = 64'h42;
        step();
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h1A; f_valP = 64'h1B;
        #1;
        n_cmp++; if (f_pc !== 64'h1A) begin n_bad++; $display("FAIL jxx_redirect got=%h exp=%h", f_pc, 64'h1A); end
        n_cmp++; if (flush_req !== 1'b1) begin n_bad++; $display("FAIL jxx_flush got=%b exp=1", flush_req); end
        step();
        M_icode = 4'h1; M_cnd = 1'b1;
        #1;
        n_cmp++; if (mispred_cnt !== 16'd1) begin n_bad++; $display("FAIL jxx_cnt got=%0d exp=1", mispred_cnt); end
        n_cmp++; if (flush_req !== 1'b0) begin n_bad++; $display("FAIL jxx_flush_clr got=%b exp=0", flush_req); end
        n_cmp++; if (f_pc !== 64'h1B) begin n_bad++; $display("FAIL jxx_after got=%h exp=%h", f_pc, 64'h1B); end
    endtask

    task automatic test_ret();
        f_icode = 4'h9; f_valP = 64'h1C;
        #1;
        n_cmp++; if (f_bubble_req !== 1'b0) begin n_bad++; $display("FAIL ret_pre_bubble got=%b exp=0", f_bubble_req); end
        step();
        n_cmp++; if (f_bubble_req !== 1'b1) begin n_bad++; $display("FAIL ret_bubble1 got=%b exp=1", f_bubble_req); end
        f_icode = 4'h1; f_valP = 64'h1D;
        step();
        n_cmp++; if (f_bubble_req !== 1'b1) begin n_bad++; $display("FAIL ret_bubble2 got=%b exp=1", f_bubble_req); end
        W_icode = 4'h9; W_valM = 64'h2C; f_valP = 64'h2D;
        #1;
        n_cmp++; if (f_pc !== 64'h2C) begin n_bad++; $display("FAIL ret_target got=%h exp=%h", f_pc, 64'h2C); end
        n_cmp++; if (flush_req !== 1'b0) begin n_bad++; $display("FAIL ret_noflush got=%b exp=0", flush_req); end
        step();
        W_icode = 4'h1;
        #1;
        n_cmp++; if (f_bubble_req !== 1'b0) begin n_bad++; $display("FAIL ret_idle got=%b exp=0", f_bubble_req); end
        n_cmp++; if (f_pc !== 64'h2D) begin n_bad++; $display("FAIL ret_after got=%h exp=%h", f_pc, 64'h2D); end
    endtask

    task automatic test_back_to_back();
        f_icode = 4'h9; f_valP = 64'h31;
        step();
        W_icode = 4'h9; W_valM = 64'h50; f_icode = 4'h9; f_valP = 64'h51;
        #1;
        n_cmp++; if (f_pc !== 64'h50) begin n_bad++; $display("FAIL b2b_target got=%h exp=%h", f_pc, 64'h50); end
        step();
        W_icode = 4'h1; f_icode = 4'h1; f_valP = 64'h52;
        #1;
        n_cmp++; if (f_bubble_req !== 1'b1) begin n_bad++; $display("FAIL b2b_rewait got=%b exp=1", f_bubble_req); end
        step();
        W_icode = 4'h9; W_valM = 64'h60; f_valP = 64'h61;
        step();
        W_icode = 4'h1;
        #1;
        n_cmp++; if (f_bubble_req !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got=%b exp=0", f_bubble_req); end
        n_cmp++; if (f_pc !== 64'h61) begin n_bad++; $display("FAIL b2b_after got=%h exp=%h", f_pc, 64'h61); end
        // wrong-path ret squashed by a jxx mispredict
        f_icode = 4'h9; f_valP = 64'h65;
        step();
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h70; f_icode = 4'h1; f_valP = 64'h71;
        #1;
        n_cmp++; if (f_pc !== 64'h70) begin n_bad++; $display("FAIL wp_redirect got=%h exp=%h", f_pc, 64'h70); end
        step();
        M_icode = 4'h1; M_cnd = 1'b1;
        #1;
        n_cmp++; if (f_bubble_req !== 1'b0) begin n_bad++; $display("FAIL wp_idle got=%b exp=0", f_bubble_req); end
        n_cmp++; if (mispred_cnt !== 16'd2) begin n_bad++; $display("FAIL wp_cnt got=%0d exp=2", mispred_cnt); end
        n_cmp++; if (f_pc !== 64'h71) begin n_bad++; $display("FAIL wp_after got=%h exp=%h", f_pc, 64'h71); end
    endtask

    task automatic test_stall();
        f_stall = 1'b1; f_icode = 4'h8; f_valC = 64'h80; f_valP = 64'h79;
        step();
        n_cmp++; if (f_pc !== 64'h71) begin n_bad++; $display("FAIL stall_hold got=%h exp=%h", f_pc, 64'h71); end
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h90;
        #1;
        n_cmp++; if (f_pc !== 64'h90) begin n_bad++; $display("FAIL stall_redirect got=%h exp=%h", f_pc, 64'h90); end
        step();
        M_icode = 4'h1; M_cnd = 1'b1;
        #1;
        n_cmp++; if (f_pc !== 64'h71) begin n_bad++; $display("FAIL stall_hold2 got=%h exp=%h", f_pc, 64'h71); end
        n_cmp++; if (mispred_cnt !== 16'd3) begin n_bad++; $display("FAIL stall_cnt got=%0d exp=3", mispred_cnt); end
        f_stall = 1'b0;
        step();
        n_cmp++; if (f_pc !== 64'h80) begin n_bad++; $display("FAIL stall_release got=%h exp=%h", f_pc, 64'h80); end
        // correctly predicted jxx in M: no redirect
        f_icode = 4'h1; f_valP = 64'h81; M_icode = 4'h7; M_cnd = 1'b1; M_valA = 64'hAA;
        #1;
        n_cmp++; if (f_pc !== 64'h80) begin n_bad++; $display("FAIL taken_ok_pc got=%h exp=%h", f_pc, 64'h80); end
        n_cmp++; if (flush_req !== 1'b0) begin n_bad++; $display("FAIL taken_ok_flush got=%b exp=0", flush_req); end
        step();
        M_icode = 4'h1;
        #1;
        n_cmp++; if (mispred_cnt !== 16'd3) begin n_bad++; $display("FAIL taken_ok_cnt got=%0d exp=3", mispred_cnt); end
    endtask

    task automatic test_saturation();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (cnt2 !== 2'd0) begin n_bad++; $display("FAIL sat_reset got=%0d exp=0", cnt2); end
        for (int i = 0; i < 5; i++) begin
            M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'hC0 + 64'(i);
            step();
            if (i == 1) begin
                n_cmp++; if (cnt2 !== 2'd2) begin n_bad++; $display("FAIL sat_mid got=%0d exp=2", cnt2); end
            end
        end
        M_icode = 4'h1; M_cnd = 1'b1;
        #1;
        n_cmp++; if (cnt2 !== 2'b11) begin n_bad++; $display("FAIL sat_hold got=%0d exp=3", cnt2); end
        n_cmp++; if (mispred_cnt !== 16'd5) begin n_bad++; $display("FAIL sat_wide got=%0d exp=5", mispred_cnt); end
    endtask

`ifdef PC_RAS_EN
    task automatic test_ras();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        f_icode = 4'h8; f_valC = 64'h200; f_valP = 64'h19;
        step();
        n_cmp++; if (f_pc !== 64'h200) begin n_bad++; $display("FAIL ras_call got=%h exp=%h", f_pc, 64'h200); end
        f_icode = 4'h9; f_valP = 64'h201;
        step();
        n_cmp++; if (f_pc !== 64'h19) begin n_bad++; $display("FAIL ras_pred got=%h exp=%h", f_pc, 64'h19); end
        n_cmp++; if (f_bubble_req !== 1'b0) begin n_bad++; $display("FAIL ras_nobubble got=%b exp=0", f_bubble_req); end
        f_icode = 4'h1; f_valP = 64'h1A; W_icode = 4'h9; W_valM = 64'h19;
        #1;
        n_cmp++; if (flush_req !== 1'b0) begin n_bad++; $display("FAIL ras_hit_flush got=%b exp=0", flush_req); end
        n_cmp++; if (f_pc !== 64'h19) begin n_bad++; $display("FAIL ras_hit_pc got=%h exp=%h", f_pc, 64'h19); end
        step();
        W_icode = 4'h1; f_icode = 4'h8; f_valC = 64'h300; f_valP = 64'h29;
        step();
        f_icode = 4'h9; f_valP = 64'h301;
        step();
        n_cmp++; if (f_pc !== 64'h29) begin n_bad++; $display("FAIL ras_pred2 got=%h exp=%h", f_pc, 64'h29); end
        f_icode = 4'h1; f_valP = 64'h2A; W_icode = 4'h9; W_valM = 64'h30;
        #1;
        n_cmp++; if (flush_req !== 1'b1) begin n_bad++; $display("FAIL ras_miss_flush got=%b exp=1", flush_req); end
        n_cmp++; if (f_pc !== 64'h30) begin n_bad++; $display("FAIL ras_miss_pc got=%h exp=%h", f_pc, 64'h30); end
        step();
        W_icode = 4'h1;
        #1;
        n_cmp++; if (mispred_cnt !== 16'd1) begin n_bad++; $display("FAIL ras_miss_cnt got=%0d exp=1", mispred_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_jxx();
        test_ret();
        test_back_to_back();
        test_stall();
        test_saturation();
`ifdef PC_RAS_EN
        test_ras();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
